// File: rtl/ram_port_master_pkg.sv
// ram_port_master_pkg: FSM state type and default widths; RAM_PORT_MASTER_TURNAROUND_EN adds the TURN state.
`ifndef B_SIZE
`define B_SIZE 8
`endif
package ram_port_master_pkg;
  localparam int DEF_ADDR_W = `B_SIZE;
  localparam int DEF_DATA_W = `B_SIZE - 3;
  typedef enum logic [2:0] {
    IDLE, WR, RD_ADDR, RD_DATA, RESP
`ifdef RAM_PORT_MASTER_TURNAROUND_EN
    , TURN
`endif
  } ram_port_master_state_t;
endpackage

// File: rtl/ram_port_master_if.sv
// ram_port_master_if: request/response channels and RAM strobes/address between control logic and the RAM master.
interface ram_port_master_if import ram_port_master_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic rsp_valid, rsp_ready, rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_cs, mem_we, mem_oe;
  modport master (
    input req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, mem_addr, mem_cs, mem_we, mem_oe
  );
  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input req_ready, rsp_valid, rsp_we, rsp_rdata, mem_addr, mem_cs, mem_we, mem_oe
  );
endinterface

// File: rtl/ram_port_tristate.sv
// ram_port_tristate: bidirectional data pad; drives out_data when drive_en, always returns the resolved bus.
module ram_port_tristate #(
  parameter int W = 8
) (
  inout wire [W-1:0] pad,
  input logic drive_en,
  input logic [W-1:0] out_data,
  output logic [W-1:0] in_data
);
  assign pad = drive_en ? out_data : {W{1'bz}};
  assign in_data = pad;
endmodule

// File: rtl/ram_port_master.sv
// ram_port_master: sequences valid/ready read/write requests into synchronous single-port RAM cycles.
// Define RAM_PORT_MASTER_TURNAROUND_EN to insert a dead TURN cycle after each read response.
module ram_port_master import ram_port_master_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic clk,
  input logic rst,
  ram_port_master_if.master bus,
  inout wire [DATA_W-1:0] mem_data
);
  ram_port_master_state_t state, next;
  logic drive, accept;
  logic [DATA_W-1:0] wdata, in_data;
  assign bus.req_ready = state == IDLE && !rst;
  assign accept = bus.req_valid && bus.req_ready;
  ram_port_tristate #(.W(DATA_W)) u_pad (
    .pad(mem_data),
    .drive_en(drive),
    .out_data(wdata),
    .in_data(in_data)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE: next = accept ? (bus.req_we ? WR : RD_ADDR) : IDLE;
      WR: next = RESP;
      RD_ADDR: next = RD_DATA;
      RD_DATA: next = RESP;
`ifdef RAM_PORT_MASTER_TURNAROUND_EN
      RESP: next = bus.rsp_ready ? (bus.rsp_we ? IDLE : TURN) : RESP;
      TURN: next = IDLE;
`else
      RESP: next = bus.rsp_ready ? IDLE : RESP;
`endif
      default: next = IDLE;
    endcase
  end
  // Strobes and pad enable are flopped from the next state so the bus sees clean registered edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      bus.mem_cs <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_oe <= 1'b0;
      bus.mem_addr <= '0;
      drive <= 1'b0;
      wdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_we <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      state <= next;
      bus.mem_cs <= next inside {WR, RD_ADDR, RD_DATA};
      bus.mem_we <= next == WR;
      bus.mem_oe <= next == RD_DATA;
      drive <= next == WR;
      bus.rsp_valid <= next == RESP;
      if (accept) begin
        bus.mem_addr <= bus.req_addr;
        wdata <= bus.req_wdata;
      end
      if (state == WR) begin
        bus.rsp_we <= 1'b1;
        bus.rsp_rdata <= '0;
      end
      if (state == RD_DATA) begin
        bus.rsp_we <= 1'b0;
        bus.rsp_rdata <= in_data;
      end
    end
  end
endmodule

// File: tb/tb_ram_port_master.sv
// tb_ram_port_master: directed and randomized transactions checked against a word-level memory model.
module tb_ram_port_master;
  import ram_port_master_pkg::*;
  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  wire [DW-1:0] mem_data;
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [DW-1:0] ram_q;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int n_chk = 0;
  int n_fail = 0;
  ram_port_master_if bus();
  ram_port_master dut (.clk(clk), .rst(rst), .bus(bus), .mem_data(mem_data));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_cs) begin
      if (bus.mem_we) ram[bus.mem_addr] <= mem_data;
      else ram_q <= ram[bus.mem_addr];
    end
  end
  assign mem_data = bus.mem_oe ? ram_q : {DW{1'bz}};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) chk("bus_conflict", dut.drive & bus.mem_oe, 1'b0);
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input int stall, input logic hold);
    logic [DW-1:0] exp;
    exp = we ? '0 : ref_mem[a];
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.rsp_ready = stall == 0;
    chk("req_ready", bus.req_ready, 1'b1);
    tick;
    bus.req_valid = hold;
    bus.req_we = 1'($urandom);
    bus.req_addr = AW'($urandom);
    bus.req_wdata = DW'($urandom);
    chk("c1_cs", bus.mem_cs, 1'b1);
    chk("c1_we", bus.mem_we, we);
    chk("c1_oe", bus.mem_oe, 1'b0);
    chk("c1_addr", bus.mem_addr, a);
    chk("c1_drive", dut.drive, we);
    chk("busy_ready", bus.req_ready, 1'b0);
    if (we) chk("wdata", mem_data, d);
    else begin
      tick;
      chk("c2_strobes", {bus.mem_cs, bus.mem_we, bus.mem_oe, dut.drive}, 4'b1010);
      chk("c2_addr", bus.mem_addr, a);
    end
    tick;
    repeat (stall) begin
      chk("stall_valid", bus.rsp_valid, 1'b1);
      chk("stall_we", bus.rsp_we, we);
      chk("stall_rdata", bus.rsp_rdata, exp);
      chk("stall_strobes", {bus.mem_cs, bus.mem_we, bus.mem_oe, dut.drive}, 4'b0);
      chk("stall_ready", bus.req_ready, 1'b0);
      tick;
    end
    bus.rsp_ready = 1'b1;
    chk("rsp_valid", bus.rsp_valid, 1'b1);
    chk("rsp_we", bus.rsp_we, we);
    chk("rsp_rdata", bus.rsp_rdata, exp);
    chk("rsp_strobes", {bus.mem_cs, bus.mem_we, bus.mem_oe, dut.drive}, 4'b0);
    tick;
    chk("rsp_done", bus.rsp_valid, 1'b0);
    if (we) ref_mem[a] = d;
`ifdef RAM_PORT_MASTER_TURNAROUND_EN
    if (!we) begin
      chk("turn_strobes", {bus.mem_cs, bus.mem_we, bus.mem_oe, dut.drive}, 4'b0);
      chk("turn_ready", bus.req_ready, 1'b0);
      tick;
    end
`endif
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) tick;
    chk("rst_ready", bus.req_ready, 1'b0);
    chk("rst_strobes", {bus.mem_cs, bus.mem_we, bus.mem_oe, dut.drive}, 4'b0);
    chk("rst_addr", bus.mem_addr, {AW{1'b0}});
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_we}, 2'b0);
    chk("rst_rdata", bus.rsp_rdata, {DW{1'b0}});
    rst = 1'b0;
    tick;
    op(1'b1, AW'(5), DW'(5'h1A), 0, 1'b0);
    op(1'b0, AW'(5), DW'(0), 0, 1'b0);
    op(1'b0, AW'(5), DW'(0), 5, 1'b0);
    op(1'b1, AW'(0), DW'(3), 0, 1'b1);
    op(1'b0, AW'(0), DW'(0), 0, 1'b1);
    op(1'b1, AW'(1), DW'(7), 0, 1'b1);
    op(1'b0, AW'(1), DW'(0), 0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b0;
    bus.req_addr = AW'(5);
    tick;
    bus.req_valid = 1'b0;
    tick;
    chk("rd_data_oe", bus.mem_oe, 1'b1);
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    tick;
    chk("abort_strobes", {bus.mem_cs, bus.mem_we, bus.mem_oe, dut.drive}, 4'b0);
    chk("abort_valid", bus.rsp_valid, 1'b0);
    chk("abort_ready", bus.req_ready, 1'b0);
    repeat (2) tick;
    rst = 1'b0;
    repeat (4) begin
      tick;
      chk("no_rsp", bus.rsp_valid, 1'b0);
    end
    for (int a = 0; a < 16; a++) op(1'b1, AW'(a), DW'($urandom), 0, 1'b1);
    for (int i = 0; i < 40; i++)
      op(1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom), $urandom_range(0, 3), 1'($urandom));
    op(1'b0, AW'(1), DW'(0), 1, 1'b0);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_port_master.md
Name: ram_port_master

Overview:
- Bus initiator for the single-port synchronous RAM interface (addr/cs/we/oe plus a shared tristate data bus).
- Converts valid/ready read and write requests from digital control logic into correctly sequenced RAM bus cycles.
- Owns bus turnaround, absorbs the RAM's one-cycle registered read latency, and returns each result on a valid/ready response channel.

Parameters:
- ADDR_W, default `b_size, RAM address width.
- DATA_W, default `b_size-3, RAM data bus width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_we  out  1  echoes the request's req_we.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- mem_addr  out  ADDR_W  RAM address.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_oe  out  1  RAM output enable.
- mem_data  inout  DATA_W  shared data bus.

Behaviour:
- FSM states: IDLE, WR, RD_ADDR, RD_DATA, RESP; TURN is present only with the optional feature. State and all bus outputs are registered.
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE.
  - mem_cs=mem_we=mem_oe=0, mem_addr=0.
  - Data bus released (Z).
  - rsp_valid=0, rsp_we=0, rsp_rdata=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation aborts the cycle; no response is issued and any in-flight write may or may not have reached the RAM.
- req_ready = (state==IDLE) & !rst. Request fields are captured on acceptance; later input changes are ignored.
- IDLE:
  - Accept with req_we=1 -> WR.
  - Accept with req_we=0 -> RD_ADDR.
- WR (1 cycle):
  - cs=1, we=1, oe=0; mem_addr = captured address; mem_data driven with captured wdata. The RAM writes at the end of this cycle.
  - Next state RESP, with rsp_we=1 and rsp_rdata=0.
- RD_ADDR (1 cycle):
  - cs=1, we=0, oe=0; mem_data = Z. The RAM registers its read data at the end of this cycle.
  - Next state RD_DATA.
- RD_DATA (1 cycle):
  - cs=1, we=0, oe=1; the RAM drives the bus.
  - mem_data is sampled into rsp_rdata at the end of this cycle.
  - Next state RESP, with rsp_we=0.
- RESP:
  - rsp_valid=1, held with stable rsp_we/rsp_rdata until rsp_ready=1.
  - cs=we=oe=0.
  - On handshake -> IDLE (or TURN, see Optional Feature).
- Latency from the accept edge to rsp_valid high: write 2 cycles, read 3 cycles.
- If rsp_ready is already high when RESP is entered, rsp_valid lasts exactly 1 cycle. Throughput: one op per 3 cycles (write) or 4 cycles (read).
- Bus ownership:
  - The master drives mem_data only in WR; Z in every other state, including reset.
  - mem_cs is never high in IDLE or RESP.
- mem_addr holds its last value when cs=0.

Optional Feature:
- Macro: RAM_PORT_MASTER_TURNAROUND_EN.
- Defined:
  - After a read response handshake, the FSM enters TURN for 1 cycle (all strobes 0, bus Z, req_ready=0), then IDLE.
  - Guarantees a dead cycle between RAM drive and master drive.
  - Write responses return to IDLE directly.
- Undefined: TURN does not exist; RESP always returns to IDLE.

Decomposition:
- Shared package: state enum type ram_port_master_state_t, plus the default width constants derived from `b_size.
- One sub-module is natural: ram_port_tristate. It is a DATA_W bidirectional pad wrapper with drive_en, out_data and in_data, keeping the inout handling isolated. The FSM stays in the top module.

Test Plan:
- Reset: hold rst 3 cycles during a read in RD_DATA -> next cycle state IDLE, cs=0, rsp_valid=0, mem_data Z, no response ever appears.
- Write: addr 0x05, wdata 0x1A -> mem_cs=mem_we=1 with mem_data=0x1A exactly 1 cycle after accept; rsp_valid with rsp_we=1, rsp_rdata=0 at +2.
- Read-back: RAM model preloaded 0x05=0x1A, read 0x05 -> cs=1/oe=0 at +1, cs=1/oe=1 at +2, rsp_rdata=0x1A and rsp_valid at +3.
- Backpressure: rsp_ready=0 for 5 cycles on a read -> rsp_valid and rsp_rdata stable, req_ready=0, no bus strobes; response completes on the first cycle rsp_ready=1.
- Back-to-back: write 0x00=0x03, read 0x00, write 0x01=0x07, read 0x01 with req_valid held -> returns 0x03 then 0x07. Checker asserts no cycle where the master drives while mem_oe=1.
- Macro on: read then write with req_valid held -> exactly one cycle with all strobes 0 and bus Z between the read RESP handshake and the write accept.
